// File: rtl/fp_sqrt_round_pack.sv
// Final rounding and packing stage for a binary32 square root: takes the raw root,
// sticky bit and biased exponent, rounds per the selected mode and packs y/flags.
module fp_sqrt_round_pack #(
    parameter int ROOT_W = 25
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ROOT_W-1:0] root,
    input  logic              sticky,
    input  logic [7:0]        exp_in,
    input  logic              sign_in,
    input  logic [1:0]        special,
    input  logic [2:0]        rounding_mode,
    output logic [31:0]       y,
    output logic [1:0]        flags,
    output logic              out_valid,
    input  logic              out_ready
);

    localparam logic [1:0] CLS_NORMAL = 2'b00;
    localparam logic [1:0] CLS_ZERO   = 2'b01;
    localparam logic [1:0] CLS_INF    = 2'b10;

    localparam logic [2:0] RM_RTZ = 3'b001;
    localparam logic [2:0] RM_RDN = 3'b010;
    localparam logic [2:0] RM_RUP = 3'b011;
    localparam logic [2:0] RM_RMM = 3'b100;

    logic              w_advance;
    logic              w_guard;
    logic              w_incr;
    logic [ROOT_W-1:0] w_sum;
    logic              w_carry;
    logic [7:0]        w_exp_rnd;
    logic [ROOT_W-3:0] w_frac;
    logic              w_unused_int;
    logic [31:0]       w_y;
    logic [1:0]        w_flags;

    logic              r_s1_valid;
    logic [ROOT_W-2:0] r_s1_mant;
    logic              r_s1_incr;
    logic              r_s1_inexact;
    logic [7:0]        r_s1_exp;
    logic              r_s1_sign;
    logic [1:0]        r_s1_special;

    logic              r_out_valid;
    logic [31:0]       r_y;
    logic [1:0]        r_flags;

    // Whole pipeline stalls as one unit whenever the output is held.
    assign w_advance = !r_out_valid || out_ready;
    assign in_ready  = w_advance;
    assign w_guard   = root[0];

    // Root is always non-negative, so RDN truncates and RUP rounds away from zero.
    always_comb begin
        w_incr = 1'b0;
        case (rounding_mode)
            RM_RTZ:  w_incr = 1'b0;
            RM_RDN:  w_incr = 1'b0;
            RM_RUP:  w_incr = w_guard | sticky;
            RM_RMM:  w_incr = w_guard;
            default: w_incr = w_guard & (sticky | root[1]);
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
        end else if (w_advance) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_mant    <= root[ROOT_W-1:1];
                r_s1_incr    <= w_incr;
                r_s1_inexact <= w_guard | sticky;
                r_s1_exp     <= exp_in;
                r_s1_sign    <= sign_in;
                r_s1_special <= special;
            end
        end
    end

    assign w_sum        = {1'b0, r_s1_mant} + {{(ROOT_W-1){1'b0}}, r_s1_incr};
    assign w_carry      = w_sum[ROOT_W-1];
    assign w_unused_int = w_sum[ROOT_W-2];
    assign w_exp_rnd    = w_carry ? r_s1_exp + 8'd1 : r_s1_exp;
    assign w_frac       = w_carry ? '0 : w_sum[ROOT_W-3:0];

    always_comb begin
        w_y     = 32'h7FC0_0000;
        w_flags = 2'b10;
        case (r_s1_special)
            CLS_NORMAL: begin
                w_y     = {1'b0, w_exp_rnd, w_frac};
                w_flags = {1'b0, r_s1_inexact};
            end
            CLS_ZERO: begin
                w_y     = {r_s1_sign, 31'b0};
                w_flags = 2'b00;
            end
            CLS_INF: begin
                w_y     = 32'h7F80_0000;
                w_flags = 2'b00;
            end
            default: begin
                w_y     = 32'h7FC0_0000;
                w_flags = 2'b10;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_y         <= 32'b0;
            r_flags     <= 2'b0;
        end else if (w_advance) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_y     <= w_y;
                r_flags <= w_flags;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign y         = r_y;
    assign flags     = r_flags;

endmodule

// File: tb/tb_fp_sqrt_round_pack.sv
// Directed bench for fp_sqrt_round_pack: vector table through the pipeline, then
// backpressure and reset-in-flight sequences.
module tb_fp_sqrt_round_pack;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [24:0] root;
    logic        sticky;
    logic [7:0]  exp_in;
    logic        sign_in;
    logic [1:0]  special;
    logic [2:0]  rounding_mode;
    logic [31:0] y;
    logic [1:0]  flags;
    logic        out_valid;
    logic        out_ready;

    int n_checks = 0;
    int n_err    = 0;

    fp_sqrt_round_pack #(.ROOT_W(25)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .root         (root),
        .sticky       (sticky),
        .exp_in       (exp_in),
        .sign_in      (sign_in),
        .special      (special),
        .rounding_mode(rounding_mode),
        .y            (y),
        .flags        (flags),
        .out_valid    (out_valid),
        .out_ready    (out_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [24:0] root;
        logic        sticky;
        logic [7:0]  exp;
        logic        sign;
        logic [1:0]  special;
        logic [2:0]  rm;
        logic [31:0] y;
        logic [1:0]  flags;
    } vec_t;

    localparam int NV = 21;
    vec_t vecs[NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        root          = v.root;
        sticky        = v.sticky;
        exp_in        = v.exp;
        sign_in       = v.sign;
        special       = v.special;
        rounding_mode = v.rm;
        in_valid      = 1'b1;
    endtask

    // Called at a negedge; returns at the negedge where the result is visible.
    task automatic send_and_check(input vec_t v, input string tag);
        int lat;
        drive(v);
        check({tag, " in_ready"}, {31'b0, in_ready}, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        check({tag, " early_valid"}, {31'b0, out_valid}, 32'd0);
        lat = 1;
        while (!out_valid && lat < 8) begin
            @(negedge clk);
            lat++;
        end
        check({tag, " latency"}, lat, 32'd2);
        check({tag, " y"}, y, v.y);
        check({tag, " flags"}, {30'b0, flags}, {30'b0, v.flags});
        $display("txn %s root=%h st=%b exp=%h sp=%b rm=%b -> y=%h flags=%b lat=%0d",
                 tag, v.root, v.sticky, v.exp, v.special, v.rm, y, flags, lat);
    endtask

    vec_t va, vb, vc, vd;

    initial begin
        //          root         st  exp    sg  sp     rm      y              fl
        vecs[0]  = '{25'h1000000, 0, 8'h80, 0, 2'b00, 3'b000, 32'h40000000, 2'b00};
        vecs[1]  = '{25'h1000003, 0, 8'h7F, 0, 2'b00, 3'b000, 32'h3F800002, 2'b01};
        vecs[2]  = '{25'h1000001, 0, 8'h7F, 0, 2'b00, 3'b000, 32'h3F800000, 2'b01};
        vecs[3]  = '{25'h1FFFFFF, 1, 8'h7F, 0, 2'b00, 3'b011, 32'h40000000, 2'b01};
        vecs[4]  = '{25'h1FFFFFF, 1, 8'h7F, 0, 2'b00, 3'b001, 32'h3FFFFFFF, 2'b01};
        vecs[5]  = '{25'h0ABCDEF, 1, 8'h12, 0, 2'b11, 3'b000, 32'h7FC00000, 2'b10};
        vecs[6]  = '{25'h1234567, 1, 8'h55, 1, 2'b01, 3'b011, 32'h80000000, 2'b00};
        vecs[7]  = '{25'h1FFFFFF, 1, 8'h20, 0, 2'b10, 3'b011, 32'h7F800000, 2'b00};
        vecs[8]  = '{25'h1000001, 1, 8'h7F, 0, 2'b00, 3'b000, 32'h3F800001, 2'b01};
        vecs[9]  = '{25'h1000003, 1, 8'h7F, 0, 2'b00, 3'b010, 32'h3F800001, 2'b01};
        vecs[10] = '{25'h1000001, 0, 8'h7F, 0, 2'b00, 3'b100, 32'h3F800001, 2'b01};
        vecs[11] = '{25'h1000000, 1, 8'h7F, 0, 2'b00, 3'b011, 32'h3F800001, 2'b01};
        vecs[12] = '{25'h1000000, 0, 8'h7F, 0, 2'b00, 3'b011, 32'h3F800000, 2'b00};
        vecs[13] = '{25'h1000001, 0, 8'h7F, 0, 2'b00, 3'b111, 32'h3F800000, 2'b01};
        vecs[14] = '{25'h1000003, 0, 8'h7F, 0, 2'b00, 3'b101, 32'h3F800002, 2'b01};
        vecs[15] = '{25'h1FFFFFF, 0, 8'hFD, 0, 2'b00, 3'b000, 32'h7F000000, 2'b01};
        vecs[16] = '{25'h1000000, 0, 8'h01, 0, 2'b00, 3'b000, 32'h00800000, 2'b00};
        vecs[17] = '{25'h1FFFFFF, 1, 8'h7F, 0, 2'b01, 3'b011, 32'h00000000, 2'b00};
        vecs[18] = '{25'h1000000, 0, 8'h80, 1, 2'b00, 3'b000, 32'h40000000, 2'b00};
        vecs[19] = '{25'h1FFFFFE, 1, 8'hFE, 1, 2'b10, 3'b100, 32'h7F800000, 2'b00};
        vecs[20] = '{25'h1555554, 1, 8'h90, 0, 2'b00, 3'b100, 32'h482AAAAA, 2'b01};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        root = '0; sticky = 1'b0; exp_in = '0; sign_in = 1'b0;
        special = '0; rounding_mode = '0;
        repeat (3) @(negedge clk);
        check("reset out_valid", {31'b0, out_valid}, 32'd0);
        check("reset y", y, 32'd0);
        check("reset flags", {30'b0, flags}, 32'd0);
        check("reset in_ready", {31'b0, in_ready}, 32'd1);
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            send_and_check(vecs[i], $sformatf("vec%0d", i));
            @(negedge clk);
        end

        // Backpressure: three back-to-back bundles, output stalled 4 cycles.
        va = vecs[1]; vb = vecs[3]; vc = vecs[5];
        drive(va);
        @(negedge clk);
        drive(vb);
        @(negedge clk);
        check("bp first valid", {31'b0, out_valid}, 32'd1);
        check("bp first y", y, va.y);
        out_ready = 1'b0;
        drive(vc);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check($sformatf("bp stall%0d in_ready", k), {31'b0, in_ready}, 32'd0);
            check($sformatf("bp stall%0d valid", k), {31'b0, out_valid}, 32'd1);
            check($sformatf("bp stall%0d y", k), y, va.y);
            check($sformatf("bp stall%0d flags", k), {30'b0, flags}, {30'b0, va.flags});
        end
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check("bp second valid", {31'b0, out_valid}, 32'd1);
        check("bp second y", y, vb.y);
        @(negedge clk);
        check("bp third valid", {31'b0, out_valid}, 32'd1);
        check("bp third y", y, vc.y);
        check("bp third flags", {30'b0, flags}, {30'b0, vc.flags});
        @(negedge clk);
        check("bp drained", {31'b0, out_valid}, 32'd0);
        $display("txn backpressure A=%h B=%h C=%h", va.y, vb.y, vc.y);

        // Reset one cycle after acceptance discards the bundle.
        vd = vecs[4];
        drive(vd);
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst mid valid", {31'b0, out_valid}, 32'd0);
        check("rst mid y", y, 32'd0);
        check("rst mid flags", {30'b0, flags}, 32'd0);
        check("rst mid in_ready", {31'b0, in_ready}, 32'd1);
        $display("txn reset-mid-flight out_valid=%b y=%h", out_valid, y);
        send_and_check(vecs[15], "post_rst");
        @(negedge clk);
        check("post_rst drained", {31'b0, out_valid}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/fp_sqrt_round_pack.md
FP_SQRT_ROUND_PACK -- requirements
Module: fp_sqrt_round_pack

Interface
REQ-001 SHALL have parameter ROOT_W, default 25, width of root input (1 integer + 23 fraction + 1 guard); only 25 is legal for binary32.
REQ-002 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port in_valid  input  1  upstream root/exponent bundle valid.
REQ-005 SHALL have port in_ready  output  1  block can accept the bundle this cycle.
REQ-006 SHALL have port root  input  ROOT_W  root[24] integer bit, root[23:1] fraction, root[0] guard.
REQ-007 SHALL have port sticky  input  1  remainder nonzero.
REQ-008 SHALL have port exp_in  input  8  biased result exponent, 1..254 for normal class.
REQ-009 SHALL have port sign_in  input  1  operand sign, used only for zero class.
REQ-010 SHALL have port special  input  2  00 normal, 01 zero, 10 +inf, 11 NaN/invalid.
REQ-011 SHALL have port rounding_mode  input  3  000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM; 101-111 treated as RNE.
REQ-012 SHALL have port y  output  32  packed IEEE-754 binary32 result.
REQ-013 SHALL have port flags  output  2  {invalid, inexact}.
REQ-014 SHALL have port out_valid  output  1  y/flags valid.
REQ-015 SHALL have port out_ready  input  1  downstream accepts y.

Function
REQ-016 SHALL be a 2-stage pipeline: S1 registers the bundle and round-increment decision, S2 registers the incremented, packed result.
REQ-017 SHALL sample root, sticky, exp_in, sign_in, special, rounding_mode only on in_valid && in_ready.
REQ-018 SHALL assert out_valid exactly 2 cycles after acceptance when unstalled; throughput one result per cycle.
REQ-019 SHALL define advance = !out_valid || out_ready; in_ready = advance; both stages move only when advance=1.
REQ-020 SHALL hold y, flags, out_valid and S1 contents stable while out_valid=1 and out_ready=0.
REQ-021 SHALL clear a stage's valid bit when it advances with no new data (bubble); no result is duplicated or dropped.
REQ-022 SHALL compute the increment for a positive root: RNE guard&(sticky|root[1]); RTZ 0; RDN 0; RUP guard|sticky; RMM guard.
REQ-023 SHALL add the increment to the 24-bit value root[24:1]; on carry-out y exponent = exp_in+1 and fraction = 0.
REQ-024 SHALL pack a normal result as {1'b0, exponent, fraction[22:0]}, inexact = guard|sticky, invalid = 0.
REQ-025 SHALL output {sign_in, 31'b0} for zero class, flags 00.
REQ-026 SHALL output 32'h7F800000 for +inf class, flags 00.
REQ-027 SHALL output canonical NaN 32'h7FC00000 for NaN class, flags 10.
REQ-028 SHALL ignore root, sticky and rounding_mode for non-normal classes.

Reset
REQ-029 SHALL, while rst=1 at a clock edge, clear both stage valid bits; out_valid=0, y=0, flags=0, in_ready=1 on the following cycle.
REQ-030 SHALL discard any in-flight bundle when rst asserts mid-operation; no out_valid pulse is produced for it.
REQ-031 SHALL accept a new bundle on the first cycle after rst deasserts.

Verification
REQ-032 SHALL pass: root=25'h1000000, sticky=0, exp_in=8'h80, special=00, RNE -> y=32'h40000000, flags=00, out_valid 2 cycles after accept.
REQ-033 SHALL pass RNE tie: root=25'h1000003, sticky=0, exp_in=8'h7F -> y=32'h3F800002, flags=01; same with root=25'h1000001 -> y=32'h3F800000, flags=01.
REQ-034 SHALL pass carry: root=25'h1FFFFFF, sticky=1, exp_in=8'h7F, RUP -> y=32'h40000000, flags=01; same with RTZ -> y=32'h3FFFFFFF.
REQ-035 SHALL pass specials: special=11 -> 32'h7FC00000, flags=10; special=01, sign_in=1 -> 32'h80000000; special=10 -> 32'h7F800000.
REQ-036 SHALL pass backpressure: 3 back-to-back bundles, out_ready=0 for 4 cycles after first out_valid -> in_ready=0, y stable, then 3 results in order, none lost.
REQ-037 SHALL pass reset mid-flight: rst=1 one cycle after accepting a bundle -> out_valid stays 0, next bundle after reset returns correct y with 2-cycle latency.
